lfsr_step_gen: RTL and testbench
================================

LFSR_STEP_GEN -- requirements
Module: lfsr_step_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000: consecutive stable synchronized samples needed to accept a key change (minimum 2).
REQ-002 SHALL have parameter AUTO_DIV, default 50000000: auto-mode step period in clk cycles (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port key_n, input, 1 bit: raw asynchronous push-button, active-low (0 = pressed).
REQ-006 SHALL have port auto_en, input, 1 bit: raw asynchronous slide switch (1 = free-running auto stepping).
REQ-007 SHALL have port step, output, 1 bit: one-cycle advance enable for the downstream LFSR/LED/7-seg stage.
REQ-008 SHALL have port key_level, output, 1 bit: debounced key state (1 = pressed).
REQ-009 SHALL have port step_count, output, 8 bits: count of step pulses issued, modulo 256.

Function
REQ-010 SHALL pass key_n and auto_en through separate 2-flop synchronizers; the FSM and prescaler use only the synchronized values.
REQ-011 SHALL implement a debounce FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a sample counter sized for DEBOUNCE_CYCLES.
REQ-012 IDLE: a pressed sample SHALL move the FSM to PRESS_WAIT with count=1; a released sample SHALL keep it in IDLE.
REQ-013 PRESS_WAIT: a released sample SHALL return to IDLE; a pressed sample SHALL increment count, and the sample that reaches DEBOUNCE_CYCLES SHALL move to PRESSED.
REQ-014 Entering PRESSED SHALL raise step for exactly the following cycle (a registered pulse); holding the key SHALL produce no further manual steps.
REQ-015 PRESSED: a released sample SHALL move to RELEASE_WAIT with count=1.
REQ-016 RELEASE_WAIT: a pressed sample SHALL return to PRESSED with no new step; DEBOUNCE_CYCLES consecutive released samples SHALL move to IDLE.
REQ-017 key_level SHALL be 1 exactly while in PRESSED or RELEASE_WAIT.
REQ-018 Auto prescaler, while synced auto_en=1: SHALL count 0..AUTO_DIV-1 and wrap, and SHALL raise an auto pulse in the cycle after count==AUTO_DIV-1.
REQ-019 Auto prescaler, while synced auto_en=0: SHALL be held at 0 with no auto pulses, so the first auto step comes AUTO_DIV cycles after auto_en is seen high.
REQ-020 step SHALL be the registered OR of the manual and auto pulses; a coincident manual and auto pulse SHALL yield a single one-cycle step, counted once.
REQ-021 step_count SHALL increment on every cycle in which step=1, wrapping from 255 to 0.
REQ-022 The debounce FSM SHALL operate identically in both modes.

Reset
REQ-023 While rst=1, outputs SHALL be forced asynchronously to step=0, key_level=0, step_count=0.
REQ-024 While rst=1, internal state SHALL be forced to FSM=IDLE, debounce count=0 and prescaler=0.
REQ-025 While rst=1, the key synchronizer SHALL be forced to 1 (released) and the auto_en synchronizer to 0.
REQ-026 Asserting rst mid-debounce or mid-count SHALL abandon the operation; a key held through reset release SHALL be debounced afresh and produce one step.

Structure
REQ-027 Package lfsr_pkg SHALL hold the FSM state typedef and the default DEBOUNCE_CYCLES and AUTO_DIV constants.
REQ-028 A sub-module sync2 (2-flop synchronizer with reset-value parameter) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4, AUTO_DIV=5; E0 = first clk edge sampling key_n=0)
REQ-029 Press: hold key_n=0 -> step=1 for only the cycle after edge E0+5; key_level=1 from the same cycle; step_count=1.
REQ-030 Bounce: key_n=0 for 3 cycles, 1 for 1 cycle, 0 for 3 cycles -> no step; step_count=0; FSM returns to IDLE.
REQ-031 Release glitch: key pressed and accepted, then a 2-cycle release glitch -> no second step; key_level stays 1.
REQ-032 Auto: auto_en=1 for 23 cycles after sync -> steps every 5 cycles, 4 pulses; step_count=4.
REQ-033 Coincidence: manual acceptance forced into the same cycle as an auto pulse -> one step cycle; step_count +1.
REQ-034 Wrap and reset: 256 steps -> step_count=0; rst asserted mid PRESS_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and default timing constants for the LFSR step generator.
package lfsr_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 20000;
    localparam int unsigned AUTO_DIV_DEF        = 50000000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/lfsr_step_gen.sv
// Step-enable generator: debounced push-button steps plus optional free-running auto steps.
module lfsr_step_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned AUTO_DIV        = AUTO_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       auto_en,
    output logic       step,
    output logic       key_level,
    output logic [7:0] step_count
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PS_W = $clog2(AUTO_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(AUTO_DIV - 1);

    logic key_sync;
    logic auto_sync;
    logic pressed;

    sync2 #(.RESET_VAL(1'b1)) u_key_sync (
        .clk (clk),
        .rst (rst),
        .d_i (key_n),
        .q_o (key_sync)
    );

    sync2 #(.RESET_VAL(1'b0)) u_auto_sync (
        .clk (clk),
        .rst (rst),
        .d_i (auto_en),
        .q_o (auto_sync)
    );

    assign pressed = ~key_sync;

    db_state_e       state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [DB_W-1:0] db_cnt_inc;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            man_pulse_d;
    logic            auto_pulse_d;
    logic            step_q;
    logic            key_level_q;
    logic [7:0]      count_q;

    assign db_cnt_inc = db_cnt_q + DB_ONE;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        man_pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_inc == DB_LAST) begin
                    state_d     = PRESSED;
                    db_cnt_d    = '0;
                    man_pulse_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end
            RELEASE_WAIT: begin
                // Bouncing back to pressed re-enters PRESSED without a new step.
                if (pressed) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_inc == DB_LAST) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        ps_d         = ps_q;
        auto_pulse_d = 1'b0;
        if (!auto_sync) begin
            ps_d = '0;
        end else if (ps_q == PS_LAST) begin
            ps_d         = '0;
            auto_pulse_d = 1'b1;
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            ps_q        <= '0;
            step_q      <= 1'b0;
            key_level_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            ps_q        <= ps_d;
            step_q      <= man_pulse_d | auto_pulse_d;
            key_level_q <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            count_q     <= count_q + {7'd0, step_q};
        end
    end

    assign step       = step_q;
    assign key_level  = key_level_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_lfsr_step_gen.sv
// Scoreboard bench: stimulus queues the cycle each step is due; a negedge monitor checks every step.
module tb_lfsr_step_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_n = 1'b1;
    logic       auto_en = 1'b0;
    logic       step;
    logic       key_level;
    logic [7:0] step_count;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int sw_count = 0;
    int exp_q[$];
    int e_cyc;
    int c;

    lfsr_step_gen #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_DIV        (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .auto_en    (auto_en),
        .step       (step),
        .key_level  (key_level),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every observed step must match the head of the queue, both in cycle and in pre-step count.
    always @(negedge clk) begin
        if (!rst && step === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_step: step=1 at cycle %0d, none expected", cyc);
            end else begin
                e_cyc = exp_q.pop_front();
                check("step_cycle", cyc, e_cyc);
            end
            check("step_count_before_step", int'(step_count), sw_count);
            sw_count = (sw_count + 1) % 256;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        sw_count = 0;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        tick(4);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check("reset_step", int'(step), 0);
        check("reset_key_level", int'(key_level), 0);
        check("reset_step_count", int'(step_count), 0);
        rst = 1'b0;
        tick(2);

        // Clean press: step due 6 negedges after the drive point.
        @(negedge clk);
        key_n = 1'b0;
        c = cyc;
        exp_q.push_back(c + 6);
        tick(5);
        check("press_key_level_early", int'(key_level), 0);
        tick(1);
        check("press_key_level", int'(key_level), 1);
        tick(3);
        check("press_step_count", int'(step_count), 1);
        check("press_hold_level", int'(key_level), 1);
        key_n = 1'b1;
        tick(10);
        check("release_key_level", int'(key_level), 0);
        drain("press_pending");

        // Release glitch shorter than the debounce window.
        @(negedge clk);
        key_n = 1'b0;
        c = cyc;
        exp_q.push_back(c + 6);
        tick(10);
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch_key_level", int'(key_level), 1);
        end
        check("glitch_step_count", int'(step_count), 2);
        key_n = 1'b1;
        tick(10);
        drain("glitch_pending");

        // Bounce: 3 pressed, 1 released, 3 pressed samples.
        do_reset();
        @(negedge clk);
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(1);
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(10);
        check("bounce_key_level", int'(key_level), 0);
        check("bounce_step_count", int'(step_count), 0);
        drain("bounce_pending");

        // Auto mode for 23 cycles: pulses every 5 cycles.
        do_reset();
        @(negedge clk);
        auto_en = 1'b1;
        c = cyc;
        for (int m = 0; m < 4; m++) exp_q.push_back(c + 7 + 5 * m);
        tick(23);
        auto_en = 1'b0;
        tick(10);
        drain("auto_pending");
        check("auto_step_count", int'(step_count), 4);

        // Manual acceptance lands on the same edge as the second auto pulse.
        do_reset();
        @(negedge clk);
        auto_en = 1'b1;
        c = cyc;
        exp_q.push_back(c + 7);
        exp_q.push_back(c + 12);
        tick(6);
        key_n = 1'b0;
        tick(7);
        auto_en = 1'b0;
        tick(6);
        check("coinc_step_count", int'(step_count), 2);
        check("coinc_key_level", int'(key_level), 1);
        key_n = 1'b1;
        tick(10);
        drain("coinc_pending");

        // Reset in PRESS_WAIT with key held through release.
        @(negedge clk);
        key_n = 1'b0;
        tick(3);
        #1 rst = 1'b1;
        exp_q.delete();
        sw_count = 0;
        #1;
        check("midrst_step", int'(step), 0);
        check("midrst_key_level", int'(key_level), 0);
        check("midrst_step_count", int'(step_count), 0);
        tick(3);
        rst = 1'b0;
        c = cyc;
        exp_q.push_back(c + 6);
        tick(9);
        check("after_rst_step_count", int'(step_count), 1);
        check("after_rst_key_level", int'(key_level), 1);
        key_n = 1'b1;
        tick(10);
        drain("after_rst_pending");

        // 256 auto steps wrap the counter back to zero.
        do_reset();
        @(negedge clk);
        auto_en = 1'b1;
        c = cyc;
        for (int m = 0; m < 256; m++) exp_q.push_back(c + 7 + 5 * m);
        tick(1283);
        auto_en = 1'b0;
        tick(10);
        drain("wrap_pending");
        check("wrap_step_count", int'(step_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
